// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-side command bus responder:
// FSM state encodings and line geometry helpers.
package mem_bus_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_XFER = 2'd2;
  localparam state_t ST_RESP = 2'd3;

  function automatic int words_of(input int offset_length);
    return 1 << offset_length;
  endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// Cache/memory command bus: one line-wide command channel and one line-wide response channel.
interface mem_bus_responder_if
  import mem_bus_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 64,
  parameter int OFFSET_LENGTH = 5
);

  localparam int LINE_W = DATA_WIDTH * words_of(OFFSET_LENGTH);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_store;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LINE_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_store;
  logic [LINE_W-1:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_store, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_store, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_store, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_store, rsp_rdata
  );

endinterface

// File: rtl/word_ram.sv
// Single-port word-wide backing RAM with a one-cycle registered read.
// Contents are never reset; they rely on the power-on / simulator zero fill.
module word_ram #(
  parameter int ADDR_W     = 14,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side endpoint: accepts one line load/store, waits a fixed latency,
// streams the line word by word through the backing RAM, then returns it.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int OFFSET_LENGTH  = 5,
  parameter int MEM_LINES_LOG2 = 10,
  parameter int LATENCY        = 4
) (
  input logic               clk,
  input logic               reset,
  mem_bus_responder_if.slave bus
);

  localparam int WORDS  = words_of(OFFSET_LENGTH);
  localparam int BEAT_W = OFFSET_LENGTH + 1;
  localparam int RAM_AW = MEM_LINES_LOG2 + OFFSET_LENGTH;
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef word_t [WORDS-1:0] line_t;

  state_t                    state_q, state_d;
  logic [LAT_W-1:0]          lat_q, lat_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [MEM_LINES_LOG2-1:0] line_q, line_d;
  logic                      store_q, store_d;
  line_t                     buf_q, buf_d;

  logic                     ram_we;
  logic [RAM_AW-1:0]        ram_addr;
  word_t                    ram_rdata;
  logic [OFFSET_LENGTH-1:0] prev_idx;

  // Loads land one beat late because of the registered RAM read.
  assign prev_idx = beat_q[OFFSET_LENGTH-1:0] - OFFSET_LENGTH'(1);
  assign ram_addr = {line_q, beat_q[OFFSET_LENGTH-1:0]};

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    line_d  = line_q;
    store_d = store_q;
    buf_d   = buf_q;
    ram_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          line_d  = bus.cmd_addr[OFFSET_LENGTH +: MEM_LINES_LOG2];
          store_d = bus.cmd_store;
          beat_d  = '0;
          if (bus.cmd_store) begin
            buf_d = bus.cmd_wdata;
          end
          if (LATENCY == 0) begin
            state_d = ST_XFER;
          end else begin
            state_d = ST_WAIT;
            lat_d   = LAT_W'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        if (lat_q == '0) begin
          state_d = ST_XFER;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ST_XFER: begin
        // Reset gates the write so an aborted store stops at the reset edge.
        ram_we = store_q && (beat_q < BEAT_W'(WORDS)) && !reset;
        if (!store_q && (beat_q != '0)) begin
          buf_d[prev_idx] = ram_rdata;
        end
        if (beat_q == BEAT_W'(WORDS)) begin
          state_d = ST_RESP;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      line_q  <= '0;
      store_q <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      store_q <= store_d;
      buf_q   <= buf_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE) && !reset;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_store = store_q;
  assign bus.rsp_rdata = buf_q;

  word_ram #(
    .ADDR_W     (RAM_AW),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (buf_q[beat_q[OFFSET_LENGTH-1:0]]),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: a LATENCY=2 and a LATENCY=0 build share one stimulus driver.
module tb_mem_bus_responder;

  localparam int DW = 8;
  localparam int OL = 2;
  localparam int ML = 4;
  localparam int AW = 64;
  localparam int LW = DW * (2**OL);

  logic clk = 1'b0;
  logic reset2, reset0;
  logic sel;
  logic tb_valid, tb_store, tb_rready;
  logic [AW-1:0] tb_addr;
  logic [LW-1:0] tb_wdata;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_bus_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OFFSET_LENGTH(OL)) if2 ();
  mem_bus_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OFFSET_LENGTH(OL)) if0 ();

  // sel routes the shared driver to the LATENCY=0 build when high.
  assign if2.cmd_valid = tb_valid && !sel;
  assign if0.cmd_valid = tb_valid && sel;
  assign if2.cmd_store = tb_store;
  assign if0.cmd_store = tb_store;
  assign if2.cmd_addr  = tb_addr;
  assign if0.cmd_addr  = tb_addr;
  assign if2.cmd_wdata = tb_wdata;
  assign if0.cmd_wdata = tb_wdata;
  assign if2.rsp_ready = tb_rready;
  assign if0.rsp_ready = tb_rready;

  logic          obs_ready, obs_rvalid, obs_rstore;
  logic [LW-1:0] obs_rdata;
  assign obs_ready  = sel ? if0.cmd_ready : if2.cmd_ready;
  assign obs_rvalid = sel ? if0.rsp_valid : if2.rsp_valid;
  assign obs_rstore = sel ? if0.rsp_store : if2.rsp_store;
  assign obs_rdata  = sel ? if0.rsp_rdata : if2.rsp_rdata;

  mem_bus_responder #(
    .DATA_WIDTH(DW), .OFFSET_LENGTH(OL), .MEM_LINES_LOG2(ML), .LATENCY(2)
  ) dut2 (
    .clk   (clk),
    .reset (reset2),
    .bus   (if2)
  );

  mem_bus_responder #(
    .DATA_WIDTH(DW), .OFFSET_LENGTH(OL), .MEM_LINES_LOG2(ML), .LATENCY(0)
  ) dut0 (
    .clk   (clk),
    .reset (reset0),
    .bus   (if0)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command and returns in the first cycle rsp_valid is high.
  task automatic applyStimulus(input logic store, input logic [AW-1:0] addr,
                               input logic [LW-1:0] wdata, input int exp_cycle,
                               input string tag);
    int   cyc;
    logic ready_ok;
    tb_valid = 1'b1;
    tb_store = store;
    tb_addr  = addr;
    tb_wdata = wdata;
    checkOutput({tag, "_accept_ready"}, 64'(obs_ready), 64'd1);
    tick();
    tb_valid = 1'b0;
    cyc      = 1;
    ready_ok = 1'b1;
    while (!obs_rvalid && cyc < 40) begin
      if (obs_ready) ready_ok = 1'b0;
      tick();
      cyc++;
    end
    if (obs_ready) ready_ok = 1'b0;
    checkOutput({tag, "_rsp_cycle"}, 64'(cyc), 64'(exp_cycle));
    checkOutput({tag, "_busy_not_ready"}, 64'(ready_ok), 64'd1);
  endtask

  initial begin
    sel       = 1'b0;
    reset2    = 1'b1;
    reset0    = 1'b1;
    tb_valid  = 1'b0;
    tb_store  = 1'b0;
    tb_addr   = '0;
    tb_wdata  = '0;
    tb_rready = 1'b1;
    tick();
    tick();
    checkOutput("in_reset_cmd_ready", 64'(obs_ready), 64'd0);
    reset2 = 1'b0;
    reset0 = 1'b0;
    #1;
    checkOutput("reset_cmd_ready", 64'(obs_ready), 64'd1);
    checkOutput("reset_rsp_valid", 64'(obs_rvalid), 64'd0);
    checkOutput("reset_rsp_store", 64'(obs_rstore), 64'd0);
    checkOutput("reset_rsp_rdata", 64'(obs_rdata), 64'd0);

    applyStimulus(1'b1, 64'h0C, 32'h44332211, 8, "store_l3");
    checkOutput("store_l3_rsp_store", 64'(obs_rstore), 64'd1);
    checkOutput("store_l3_rsp_rdata", 64'(obs_rdata), 64'h44332211);
    tick();
    checkOutput("store_l3_rsp_done", 64'(obs_rvalid), 64'd0);

    applyStimulus(1'b0, 64'h0C, '0, 8, "load_l3");
    checkOutput("load_l3_rsp_store", 64'(obs_rstore), 64'd0);
    checkOutput("load_l3_rsp_rdata", 64'(obs_rdata), 64'h44332211);
    tick();

    tb_rready = 1'b0;
    applyStimulus(1'b0, 64'h4C, '0, 8, "load_alias");
    checkOutput("load_alias_rsp_store", 64'(obs_rstore), 64'd0);
    checkOutput("load_alias_rsp_rdata", 64'(obs_rdata), 64'h44332211);

    tb_valid = 1'b1;
    tb_store = 1'b0;
    tb_addr  = 64'h14;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_rsp_valid", 64'(obs_rvalid), 64'd1);
      checkOutput("stall_rsp_rdata", 64'(obs_rdata), 64'h44332211);
      checkOutput("stall_cmd_ready", 64'(obs_ready), 64'd0);
    end
    tb_rready = 1'b1;
    tick();
    checkOutput("after_hs_rsp_valid", 64'(obs_rvalid), 64'd0);
    checkOutput("after_hs_cmd_ready", 64'(obs_ready), 64'd1);

    applyStimulus(1'b0, 64'h14, '0, 8, "load_l5");
    checkOutput("load_l5_rsp_rdata", 64'(obs_rdata), 64'h00000000);
    tick();

    sel = 1'b1;
    #1;
    applyStimulus(1'b0, 64'h08, '0, 6, "lat0_load_l2");
    checkOutput("lat0_load_l2_rsp_rdata", 64'(obs_rdata), 64'h00000000);
    tick();

    tb_valid = 1'b1;
    tb_store = 1'b1;
    tb_addr  = 64'h04;
    tb_wdata = 32'hFFFFFFFF;
    checkOutput("abort_accept_ready", 64'(obs_ready), 64'd1);
    tick();
    tb_valid = 1'b0;
    tick();
    tick();
    tick();
    reset0 = 1'b1;
    tick();
    checkOutput("abort_cmd_ready", 64'(obs_ready), 64'd0);
    checkOutput("abort_rsp_valid", 64'(obs_rvalid), 64'd0);
    checkOutput("abort_rsp_store", 64'(obs_rstore), 64'd0);
    checkOutput("abort_rsp_rdata", 64'(obs_rdata), 64'd0);
    reset0 = 1'b0;
    #1;
    checkOutput("abort_idle_ready", 64'(obs_ready), 64'd1);

    applyStimulus(1'b0, 64'h04, '0, 6, "lat0_load_l1");
    checkOutput("lat0_load_l1_rsp_rdata", 64'(obs_rdata), 64'h00FFFFFF);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
